// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending datapath types and coin table
package vend_pkg;

    localparam int N_COIN_DEF = 4;
    localparam int WIDTH_DEF  = 16;

    typedef enum logic {IDLE, CHANGE} state_t;
    typedef logic [WIDTH_DEF-1:0] price_t;

    // Denomination table; index 0 is the largest coin, values strictly descending.
    function automatic int unsigned coin_value(input int k);
        case (k)
            0:       return 32'd1000;
            1:       return 32'd500;
            2:       return 32'd100;
            3:       return 32'd50;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/credit_bank_if.sv
// rtl/credit_bank_if.sv - coin, purchase and change handshake bundle
interface credit_bank_if #(
    parameter int WIDTH  = 16,
    parameter int N_COIN = 4,
    parameter int N_ITEM = 2
);
    localparam int SEL_W = (N_ITEM > 1) ? $clog2(N_ITEM) : 1;

    logic [N_COIN-1:0]       coin_in;
    logic                    coin_reject;
    logic                    buy_req;
    logic [SEL_W-1:0]        buy_sel;
    logic [N_ITEM*WIDTH-1:0] price;
    logic                    buy_ack;
    logic                    buy_nak;
    logic                    return_req;
    logic                    chg_valid;
    logic [N_COIN-1:0]       chg_coin;
    logic                    chg_ready;
    logic [WIDTH-1:0]        credit;
    logic                    busy;

    modport master (
        output coin_in, buy_req, buy_sel, price, return_req, chg_ready,
        input  coin_reject, buy_ack, buy_nak, chg_valid, chg_coin, credit, busy
    );

    modport slave (
        input  coin_in, buy_req, buy_sel, price, return_req, chg_ready,
        output coin_reject, buy_ack, buy_nak, chg_valid, chg_coin, credit, busy
    );
endinterface

// File: rtl/chg_coin_sel.sv
// rtl/chg_coin_sel.sv - picks the largest denomination that fits in the credit
module chg_coin_sel
    import vend_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int N_COIN = N_COIN_DEF
) (
    input  logic [WIDTH-1:0]  credit,
    output logic [N_COIN-1:0] coin,
    output logic [WIDTH-1:0]  value,
    output logic              none
);

    // Scan smallest to largest so the last (largest) fitting coin wins.
    always_comb begin
        coin  = '0;
        value = '0;
        none  = 1'b1;
        for (int k = N_COIN - 1; k >= 0; k--) begin
            if (credit >= WIDTH'(coin_value(k))) begin
                coin    = '0;
                coin[k] = 1'b1;
                value   = WIDTH'(coin_value(k));
                none    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/credit_bank.sv
// rtl/credit_bank.sv - credit register with coin accept, purchase settle and change return
module credit_bank
    import vend_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int N_COIN     = N_COIN_DEF,
    parameter int N_ITEM     = 2,
    parameter int MAX_CREDIT = 9950
) (
    input  logic         clk,
    input  logic         rst_n,
    credit_bank_if.slave bus
);

    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_CREDIT);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(coin_value(N_COIN - 1));

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  credit_q, credit_nxt;
    logic              reject_q, reject_nxt;
    logic              ack_q, ack_nxt;
    logic              nak_q, nak_nxt;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    coin_val;
    logic [WIDTH-1:0]  item_price;
    logic [N_COIN-1:0] sel_coin;
    logic [WIDTH-1:0]  sel_value;
    logic              sel_none;

    // The offered change coin is always the largest one fitting the held credit,
    // so it stays stable for as long as the hopper stalls.
    chg_coin_sel #(.WIDTH(WIDTH), .N_COIN(N_COIN)) u_sel (
        .credit (credit_q),
        .coin   (sel_coin),
        .value  (sel_value),
        .none   (sel_none)
    );

    // Next-state and settlement arithmetic: coin first, then purchase, then return.
    always_comb begin
        state_nxt  = state;
        credit_nxt = credit_q;
        reject_nxt = 1'b0;
        ack_nxt    = 1'b0;
        nak_nxt    = 1'b0;
        sum        = {1'b0, credit_q};
        coin_val   = '0;
        item_price = '0;
        for (int k = 0; k < N_COIN; k++) begin
            if (bus.coin_in[k]) coin_val = (WIDTH+1)'(coin_value(k));
        end
        for (int i = 0; i < N_ITEM; i++) begin
            if (int'(bus.buy_sel) == i) item_price = bus.price[i*WIDTH +: WIDTH];
        end
        case (state)
            IDLE: begin
                if (bus.coin_in != '0) begin
                    if ($onehot(bus.coin_in) && (sum + coin_val <= MAX_W)) sum = sum + coin_val;
                    else reject_nxt = 1'b1;
                end
                if (bus.buy_req) begin
                    if ((int'(bus.buy_sel) < N_ITEM) && ({1'b0, item_price} <= sum)) begin
                        ack_nxt = 1'b1;
                        sum     = sum - {1'b0, item_price};
                    end else begin
                        nak_nxt = 1'b1;
                    end
                end
                credit_nxt = sum[WIDTH-1:0];
                if (bus.return_req && (credit_nxt >= MIN_W)) state_nxt = CHANGE;
            end
            CHANGE: begin
                reject_nxt = (bus.coin_in != '0);
                nak_nxt    = bus.buy_req;
                if (sel_none) begin
                    state_nxt = IDLE;
                end else if (bus.chg_ready && (credit_q >= sel_value)) begin
                    credit_nxt = credit_q - sel_value;
                    if (credit_nxt < MIN_W) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, credit and event pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
            ack_q    <= 1'b0;
            nak_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit_q <= credit_nxt;
            reject_q <= reject_nxt;
            ack_q    <= ack_nxt;
            nak_q    <= nak_nxt;
        end
    end

    assign bus.credit      = credit_q;
    assign bus.coin_reject = reject_q;
    assign bus.buy_ack     = ack_q;
    assign bus.buy_nak     = nak_q;
    assign bus.busy        = (state == CHANGE);
    assign bus.chg_valid   = (state == CHANGE);
    assign bus.chg_coin    = (state == CHANGE) ? sel_coin : '0;

endmodule

// File: tb/tb_credit_bank.sv
// tb/tb_credit_bank.sv - directed self-checking bench for credit_bank
module tb_credit_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [3:0] C1000 = 4'b0001;
    localparam logic [3:0] C500  = 4'b0010;
    localparam logic [3:0] C100  = 4'b0100;
    localparam logic [3:0] C50   = 4'b1000;

    always #5 clk = ~clk;

    credit_bank_if #(.WIDTH(16), .N_COIN(4), .N_ITEM(2)) bus ();

    credit_bank #(.WIDTH(16), .N_COIN(4), .N_ITEM(2), .MAX_CREDIT(9950)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic insert(input logic [3:0] c);
        bus.coin_in = c;
        cycle();
        bus.coin_in = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        vectors++;
        if (bus.credit !== 16'd0) begin miscompares++; $display("FAIL reset_credit: got %0d expected 0", bus.credit); end
        vectors++;
        if ({bus.chg_valid, bus.busy, bus.coin_reject, bus.buy_ack, bus.buy_nak} !== 5'b0) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 00000",
                {bus.chg_valid, bus.busy, bus.coin_reject, bus.buy_ack, bus.buy_nak});
        end
        vectors++;
        if (bus.chg_coin !== 4'b0) begin miscompares++; $display("FAIL reset_chg_coin: got %b expected 0000", bus.chg_coin); end
        rst_n = 1'b1;
    endtask

    task automatic test_coin_accept();
        logic [3:0] seq [3];
        int         exp_credit [3];
        seq = '{C1000, C500, C100};
        exp_credit = '{1000, 1500, 1600};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            insert(seq[i]);
            vectors++;
            if (bus.coin_reject !== 1'b0) begin miscompares++; $display("FAIL accept_reject[%0d]: got %b expected 0", i, bus.coin_reject); end
            vectors++;
            if (bus.credit !== 16'(exp_credit[i])) begin miscompares++; $display("FAIL accept_credit[%0d]: got %0d expected %0d", i, bus.credit, exp_credit[i]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) insert(C1000);
        insert(C500);
        vectors++;
        if (bus.credit !== 16'd9500) begin miscompares++; $display("FAIL ovf_setup: got %0d expected 9500", bus.credit); end
        insert(C1000);
        vectors++;
        if (bus.coin_reject !== 1'b1 || bus.credit !== 16'd9500) begin
            miscompares++; $display("FAIL ovf_reject_1000: got rej=%b credit=%0d expected rej=1 credit=9500", bus.coin_reject, bus.credit);
        end
        insert(C50);
        vectors++;
        if (bus.coin_reject !== 1'b0 || bus.credit !== 16'd9550) begin
            miscompares++; $display("FAIL ovf_accept_50: got rej=%b credit=%0d expected rej=0 credit=9550", bus.coin_reject, bus.credit);
        end
        insert(4'b0011);
        vectors++;
        if (bus.coin_reject !== 1'b1 || bus.credit !== 16'd9550) begin
            miscompares++; $display("FAIL multi_hot: got rej=%b credit=%0d expected rej=1 credit=9550", bus.coin_reject, bus.credit);
        end
        for (int i = 0; i < 4; i++) insert(C100);
        vectors++;
        if (bus.coin_reject !== 1'b0 || bus.credit !== 16'd9950) begin
            miscompares++; $display("FAIL ovf_exact_max: got rej=%b credit=%0d expected rej=0 credit=9950", bus.coin_reject, bus.credit);
        end
        insert(C50);
        vectors++;
        if (bus.coin_reject !== 1'b1 || bus.credit !== 16'd9950) begin
            miscompares++; $display("FAIL ovf_above_max: got rej=%b credit=%0d expected rej=1 credit=9950", bus.coin_reject, bus.credit);
        end
    endtask

    task automatic test_buy();
        do_reset();
        insert(C500);
        insert(C100);
        bus.buy_req = 1'b1; bus.buy_sel = 1'b0;
        cycle();
        bus.buy_req = 1'b0;
        vectors++;
        if ({bus.buy_ack, bus.buy_nak} !== 2'b01 || bus.credit !== 16'd600) begin
            miscompares++; $display("FAIL buy_short: got ack/nak=%b credit=%0d expected 01 credit=600", {bus.buy_ack, bus.buy_nak}, bus.credit);
        end
        bus.coin_in = C100; bus.buy_req = 1'b1; bus.buy_sel = 1'b0;
        cycle();
        bus.coin_in = '0; bus.buy_req = 1'b0;
        vectors++;
        if ({bus.buy_ack, bus.buy_nak} !== 2'b10 || bus.credit !== 16'd0) begin
            miscompares++; $display("FAIL buy_with_coin: got ack/nak=%b credit=%0d expected 10 credit=0", {bus.buy_ack, bus.buy_nak}, bus.credit);
        end
        bus.buy_req = 1'b1; bus.buy_sel = 1'b1;
        cycle();
        bus.buy_req = 1'b0;
        vectors++;
        if ({bus.buy_ack, bus.buy_nak} !== 2'b01) begin
            miscompares++; $display("FAIL buy_item1_broke: got ack/nak=%b expected 01", {bus.buy_ack, bus.buy_nak});
        end
        bus.price = {16'd0, 16'd700};
        bus.buy_req = 1'b1; bus.buy_sel = 1'b1;
        cycle();
        bus.buy_req = 1'b0;
        vectors++;
        if ({bus.buy_ack, bus.buy_nak} !== 2'b10 || bus.credit !== 16'd0) begin
            miscompares++; $display("FAIL buy_free: got ack/nak=%b credit=%0d expected 10 credit=0", {bus.buy_ack, bus.buy_nak}, bus.credit);
        end
        bus.price = {16'd250, 16'd700};
    endtask

    task automatic test_change();
        logic [3:0] exp_coin [4];
        int         exp_credit [4];
        exp_coin = '{C1000, C500, C100, C50};
        exp_credit = '{1650, 650, 150, 50};
        do_reset();
        insert(C1000); insert(C500); insert(C100); insert(C50);
        bus.chg_ready = 1'b0;
        bus.return_req = 1'b1;
        cycle();
        bus.return_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.chg_valid !== 1'b1 || bus.busy !== 1'b1 || bus.chg_coin !== C1000 || bus.credit !== 16'd1650) begin
                miscompares++; $display("FAIL chg_stall[%0d]: got v=%b busy=%b coin=%b credit=%0d expected v=1 busy=1 coin=0001 credit=1650",
                    i, bus.chg_valid, bus.busy, bus.chg_coin, bus.credit);
            end
            cycle();
        end
        bus.chg_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.chg_valid !== 1'b1 || bus.chg_coin !== exp_coin[i] || bus.credit !== 16'(exp_credit[i])) begin
                miscompares++; $display("FAIL chg_seq[%0d]: got v=%b coin=%b credit=%0d expected v=1 coin=%b credit=%0d",
                    i, bus.chg_valid, bus.chg_coin, bus.credit, exp_coin[i], exp_credit[i]);
            end
            cycle();
        end
        bus.chg_ready = 1'b0;
        vectors++;
        if (bus.chg_valid !== 1'b0 || bus.busy !== 1'b0 || bus.chg_coin !== 4'b0 || bus.credit !== 16'd0) begin
            miscompares++; $display("FAIL chg_done: got v=%b busy=%b coin=%b credit=%0d expected 0 0 0000 0",
                bus.chg_valid, bus.busy, bus.chg_coin, bus.credit);
        end
    endtask

    task automatic test_change_lockout();
        do_reset();
        insert(C1000); insert(C500);
        bus.chg_ready = 1'b0;
        bus.return_req = 1'b1;
        cycle();
        bus.return_req = 1'b0;
        insert(C100);
        vectors++;
        if (bus.coin_reject !== 1'b1 || bus.credit !== 16'd1500) begin
            miscompares++; $display("FAIL chg_coin_reject: got rej=%b credit=%0d expected rej=1 credit=1500", bus.coin_reject, bus.credit);
        end
        bus.buy_req = 1'b1; bus.buy_sel = 1'b1;
        cycle();
        bus.buy_req = 1'b0;
        vectors++;
        if ({bus.buy_ack, bus.buy_nak} !== 2'b01 || bus.credit !== 16'd1500) begin
            miscompares++; $display("FAIL chg_buy_nak: got ack/nak=%b credit=%0d expected 01 credit=1500", {bus.buy_ack, bus.buy_nak}, bus.credit);
        end
        bus.return_req = 1'b1;
        cycle();
        bus.return_req = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.chg_coin !== C1000) begin
            miscompares++; $display("FAIL chg_return_ignored: got busy=%b coin=%b expected busy=1 coin=0001", bus.busy, bus.chg_coin);
        end
        bus.chg_ready = 1'b1;
        cycle();
        cycle();
        bus.chg_ready = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.credit !== 16'd0) begin
            miscompares++; $display("FAIL lockout_drain: got busy=%b credit=%0d expected busy=0 credit=0", bus.busy, bus.credit);
        end
        bus.return_req = 1'b1;
        cycle();
        bus.return_req = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.chg_valid !== 1'b0) begin
            miscompares++; $display("FAIL return_zero: got busy=%b v=%b expected busy=0 v=0", bus.busy, bus.chg_valid);
        end
    endtask

    task automatic test_reset_mid_change();
        do_reset();
        insert(C1000); insert(C500);
        bus.chg_ready = 1'b1;
        bus.return_req = 1'b1;
        cycle();
        bus.return_req = 1'b0;
        cycle();
        bus.chg_ready = 1'b0;
        vectors++;
        if (bus.chg_coin !== C500 || bus.credit !== 16'd500) begin
            miscompares++; $display("FAIL midchg_setup: got coin=%b credit=%0d expected coin=0010 credit=500", bus.chg_coin, bus.credit);
        end
        rst_n = 1'b0;
        #2;
        vectors++;
        if (bus.chg_valid !== 1'b0 || bus.busy !== 1'b0 || bus.credit !== 16'd0) begin
            miscompares++; $display("FAIL midchg_async_reset: got v=%b busy=%b credit=%0d expected 0 0 0",
                bus.chg_valid, bus.busy, bus.credit);
        end
        rst_n = 1'b1;
        cycle();
        vectors++;
        if (bus.busy !== 1'b0 || bus.chg_valid !== 1'b0 || bus.chg_coin !== 4'b0) begin
            miscompares++; $display("FAIL midchg_idle_after: got busy=%b v=%b coin=%b expected 0 0 0000",
                bus.busy, bus.chg_valid, bus.chg_coin);
        end
    endtask

    initial begin
        bus.coin_in    = '0;
        bus.buy_req    = 1'b0;
        bus.buy_sel    = 1'b0;
        bus.price      = {16'd250, 16'd700};
        bus.return_req = 1'b0;
        bus.chg_ready  = 1'b0;
        test_reset();
        test_coin_accept();
        test_overflow();
        test_buy();
        test_change();
        test_change_lockout();
        test_reset_mid_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
